// File: rtl/id_stage.sv
// Instruction decode stage: 32-entry register file with optional write-back
// forwarding, load-use hazard detection, and the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_W    = 32,
  parameter int WB_BYPASS = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_4,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              out_valid,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] jump_dest
);

  localparam logic [5:0] OP_LW = 6'h23;

  logic [DATA_W-1:0]        regFile [32];
  logic [4:0]               rsIdx;
  logic [4:0]               rtIdx;
  logic [DATA_W-1:0]        rsRead;
  logic [DATA_W-1:0]        rtRead;
  logic signed [DATA_W-1:0] immExt;
  logic [DATA_W-1:0]        jumpTarget;
  logic                     loadUse;
  logic                     unusedPcBits;

  logic                     vld_p1;
  logic [5:0]               opcode_p1;
  logic [5:0]               funct_p1;
  logic [4:0]               rt_p1;
  logic [4:0]               rd_p1;
  logic [DATA_W-1:0]        rsData_p1;
  logic [DATA_W-1:0]        rtData_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        jumpDest_p1;

  // A register read port: $0 is hard-wired to zero; a same-cycle write to the
  // index being read is forwarded when bypassing is enabled.
  function automatic logic [DATA_W-1:0] readPort(
    input logic [4:0]        idx,
    input logic [DATA_W-1:0] stored,
    input logic              weIn,
    input logic [4:0]        addrIn,
    input logic [DATA_W-1:0] dataIn
  );
    if (idx == 5'd0) return '0;
    if ((WB_BYPASS != 0) && weIn && (addrIn == idx)) return dataIn;
    return stored;
  endfunction

  // Sign-extend the 16-bit immediate field to the datapath width.
  function automatic logic signed [DATA_W-1:0] signExtend16(input logic [15:0] half);
    return {{(DATA_W-16){half[15]}}, half};
  endfunction

  assign rsIdx        = instr[25:21];
  assign rtIdx        = instr[20:16];
  assign rsRead       = readPort(rsIdx, regFile[rsIdx], wb_we, wb_addr, wb_data);
  assign rtRead       = readPort(rtIdx, regFile[rtIdx], wb_we, wb_addr, wb_data);
  assign immExt       = signExtend16(instr[15:0]);
  assign jumpTarget   = {pc_4[DATA_W-1:28], instr[25:0], 2'b00};
  // Low PC bits are replaced by the jump field and never observed.
  assign unusedPcBits = ^pc_4[27:0];

  // Load-use detection against the instruction currently held in ID/EX.
  generate
    if (HAZARD_EN != 0) begin : genHazard
      assign loadUse = in_valid & vld_p1 & ~flush & (opcode_p1 == OP_LW) &
                       (rt_p1 != 5'd0) & ((rt_p1 == rsIdx) | (rt_p1 == rtIdx));
    end else begin : genNoHazard
      assign loadUse = 1'b0;
    end
  endgenerate

  assign stall = loadUse;

  // Register file write port; entry 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regFile[wb_addr] <= wb_data;
    end
  end

  // ---- ID -> EX boundary ----
  // Flush and stall both insert a bubble and keep the previous fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      opcode_p1   <= '0;
      funct_p1    <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      rsData_p1   <= '0;
      rtData_p1   <= '0;
      imm_p1      <= '0;
      jumpDest_p1 <= '0;
    end else if (flush || loadUse) begin
      vld_p1      <= 1'b0;
    end else begin
      vld_p1      <= in_valid;
      opcode_p1   <= instr[31:26];
      funct_p1    <= instr[5:0];
      rt_p1       <= rtIdx;
      rd_p1       <= instr[15:11];
      rsData_p1   <= rsRead;
      rtData_p1   <= rtRead;
      imm_p1      <= immExt;
      jumpDest_p1 <= jumpTarget;
    end
  end

  assign out_valid = vld_p1;
  assign opcode    = opcode_p1;
  assign funct     = funct_p1;
  assign rt        = rt_p1;
  assign rd        = rd_p1;
  assign rs_data   = rsData_p1;
  assign rt_data   = rtData_p1;
  assign imm       = imm_p1;
  assign jump_dest = jumpDest_p1;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by constrained-random
// traffic, checked against an architectural model of decode behaviour.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc_4;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;

  logic        stall, out_valid;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data, imm, jump_dest;
  logic [4:0]  rt, rd;

  logic        stallNb, outValidNb;
  logic [5:0]  opcodeNb, functNb;
  logic [31:0] rsDataNb, rtDataNb, immNb, jumpDestNb;
  logic [4:0]  rtNb, rdNb;

  int nVec = 0;
  int nMis = 0;

  // Architectural model state
  logic [31:0] mRegs [32];
  bit          mVld;
  logic [5:0]  mOp, mFn;
  logic [4:0]  mRt, mRd;
  logic [31:0] mRs1, mRt1, mRs0, mRt0, mImm, mJd;
  bit          lastStall;

  id_stage #(.DATA_W(32), .WB_BYPASS(1), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .pc_4(pc_4),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .stall(stall), .out_valid(out_valid), .opcode(opcode), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .rt(rt), .rd(rd), .imm(imm),
    .jump_dest(jump_dest)
  );

  id_stage #(.DATA_W(32), .WB_BYPASS(0), .HAZARD_EN(1)) dutNb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .pc_4(pc_4),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .stall(stallNb), .out_valid(outValidNb), .opcode(opcodeNb), .funct(functNb),
    .rs_data(rsDataNb), .rt_data(rtDataNb), .rt(rtNb), .rd(rdNb), .imm(immNb),
    .jump_dest(jumpDestNb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mVld = 0; mOp = '0; mFn = '0; mRt = '0; mRd = '0;
    mRs1 = '0; mRt1 = '0; mRs0 = '0; mRt0 = '0; mImm = '0; mJd = '0;
    lastStall = 0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && wb_we && (wb_addr == idx)) return wb_data;
    return mRegs[idx];
  endfunction

  task automatic checkOutputs();
    check("out_valid", out_valid, mVld);
    check("opcode", opcode, mOp);
    check("funct", funct, mFn);
    check("rt", rt, mRt);
    check("rd", rd, mRd);
    check("rs_data", rs_data, mRs1);
    check("rt_data", rt_data, mRt1);
    check("imm", imm, mImm);
    check("jump_dest", jump_dest, mJd);
    check("nb_out_valid", outValidNb, mVld);
    check("nb_opcode", opcodeNb, mOp);
    check("nb_funct", functNb, mFn);
    check("nb_rt", rtNb, mRt);
    check("nb_rd", rdNb, mRd);
    check("nb_rs_data", rsDataNb, mRs0);
    check("nb_rt_data", rtDataNb, mRt0);
    check("nb_imm", immNb, mImm);
    check("nb_jump_dest", jumpDestNb, mJd);
  endtask

  // Apply the current inputs for one clock and compare against the model.
  task automatic step();
    logic [4:0]  rsI, rtI;
    logic [31:0] r1s, r1t, r0s, r0t;
    bit          expStall;
    rsI = instr[25:21];
    rtI = instr[20:16];
    expStall = in_valid && mVld && !flush && (mOp == 6'h23) && (mRt != 5'd0) &&
               ((mRt == rsI) || (mRt == rtI));
    r1s = modelRead(rsI, 1'b1);
    r1t = modelRead(rtI, 1'b1);
    r0s = modelRead(rsI, 1'b0);
    r0t = modelRead(rtI, 1'b0);
    #1;
    check("stall", stall, expStall);
    check("nb_stall", stallNb, expStall);
    @(posedge clk);
    if (flush || expStall) begin
      mVld = 0;
    end else begin
      mVld = in_valid;
      mOp  = instr[31:26];
      mFn  = instr[5:0];
      mRt  = rtI;
      mRd  = instr[15:11];
      mRs1 = r1s; mRt1 = r1t; mRs0 = r0s; mRt0 = r0t;
      mImm = instr[15] ? (32'hFFFF_0000 | {16'h0, instr[15:0]}) : {16'h0, instr[15:0]};
      mJd  = (pc_4 & 32'hF000_0000) | ({6'b0, instr[25:0]} << 2);
    end
    if (wb_we && (wb_addr != 5'd0)) mRegs[wb_addr] = wb_data;
    lastStall = expStall;
    #1;
    checkOutputs();
  endtask

  function automatic logic [31:0] rType(input int rs, input int rtv, input int rdv, input int fn);
    return (32'(rs) << 21) | (32'(rtv) << 16) | (32'(rdv) << 11) | 32'(fn);
  endfunction

  initial begin
    logic [5:0] op;
    clearModel();
    rst_n = 1'b1; in_valid = 0; instr = '0; pc_4 = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; flush = 0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_rs_data", rs_data, 0);
    check("rst_imm", imm, 0);
    check("rst_jump_dest", jump_dest, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write r5, then add $3,$5,$0
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
    step();
    wb_we = 0; in_valid = 1; instr = rType(5, 0, 3, 6'h20); pc_4 = 32'h0000_0004;
    step();
    check("add_rs_data", rs_data, 32'h1234);
    check("add_rt_data", rt_data, 32'h0);
    check("add_out_valid", out_valid, 1);

    // Same-cycle write-back of r7 while reading it as rs
    wb_we = 1; wb_addr = 7; wb_data = 32'hCAFE; instr = rType(7, 0, 4, 6'h20);
    step();
    check("byp_rs_data", rs_data, 32'hCAFE);
    check("nobyp_rs_data", rsDataNb, 32'h0);
    wb_we = 0;

    // lw $8,0($1) then add $9,$8,$2 ; write r10 during the stall cycle
    instr = 32'h8C28_0000;
    step();
    instr = rType(8, 2, 9, 6'h20);
    wb_we = 1; wb_addr = 10; wb_data = 32'hA5A5;
    #1 check("lu_stall_hi", stall, 1);
    step();
    check("lu_bubble", out_valid, 0);
    wb_we = 0;
    step();
    check("lu_issue_valid", out_valid, 1);
    check("lu_issue_rd", rd, 9);
    instr = rType(10, 0, 1, 6'h20);
    step();
    check("wb_in_stall_commit", rs_data, 32'hA5A5);

    // lw $0 followed by reader of $0; write to r0 is ignored
    instr = 32'h8C20_0004;
    step();
    instr = rType(0, 0, 2, 6'h20); wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
    #1 check("r0_no_stall", stall, 0);
    step();
    wb_we = 0;
    step();
    check("r0_reads_zero", rs_data, 0);

    // Immediate sign extension and jump target
    instr = 32'h2002_FFFC; pc_4 = 32'h4000_0010;
    step();
    check("imm_sext", imm, 32'hFFFF_FFFC);
    instr = 32'h0810_0000;
    step();
    check("jump_dest", jump_dest, 32'h4040_0000);

    // Flush during a load-use match
    instr = 32'h8C28_0000;
    step();
    instr = rType(8, 2, 9, 6'h20); flush = 1;
    #1 check("flush_no_stall", stall, 0);
    step();
    check("flush_bubble", out_valid, 0);
    flush = 0;
    step();
    check("post_flush_valid", out_valid, 1);

    // Reset pulse in the middle of a stall
    instr = 32'h8C28_0000;
    step();
    instr = rType(8, 5, 9, 6'h20);
    #1 check("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_opcode", opcode, 0);
    check("midrst_rt", rt, 0);
    check("midrst_rs_data", rs_data, 0);
    check("midrst_imm", imm, 0);
    check("midrst_jump_dest", jump_dest, 0);
    clearModel();
    #1 rst_n = 1'b1;
    instr = rType(5, 10, 3, 6'h20);
    step();
    check("rf_cleared", rs_data, 0);

    // Constrained-random traffic; fetch holds its instruction while stalled
    for (int i = 0; i < 300; i++) begin
      if (!lastStall) begin
        in_valid = ($urandom_range(0, 9) != 0);
        op = ($urandom_range(0, 2) == 0) ? 6'h23 : 6'($urandom);
        instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        pc_4 = $urandom;
      end
      wb_we   = ($urandom_range(0, 1) == 1);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
